ifetch_unit: RTL and testbench

- Instruction-fetch stage of the multi-cycle MIPS core.
- Holds the PC and fetches one word per instruction from instruction memory using a req/ack handshake.
- Latches the fetched word and presents it to the decode/control stage (opcode = Instruction[31:26], function = Instruction[5:0]).
- Computes the next PC from the control stage's branch/jump decisions and the ALU results.

---
 rtl/ifetch_unit_pkg.sv | 21 ++
 rtl/ifetch_unit_npc_select.sv | 48 ++++
 rtl/ifetch_unit.sv | 135 +++++++++++++
 tb/tb_ifetch_unit.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/ifetch_unit_pkg.sv
// Shared definitions for the instruction-fetch stage: FSM encoding, default
// parameters and instruction field positions.
package ifetch_unit_pkg;

   localparam int          DEFAULT_PC_WIDTH = 32;
   localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

   localparam int OP_MSB     = 31;
   localparam int OP_LSB     = 26;
   localparam int FUNC_MSB   = 5;
   localparam int FUNC_LSB   = 0;
   localparam int TARGET_MSB = 25;
   localparam int TARGET_LSB = 0;

   typedef enum logic [1:0] {
      S_REQ   = 2'b00,
      S_EXEC  = 2'b01,
      S_FAULT = 2'b10
   } state_t;

endpackage

// File: rtl/ifetch_unit_npc_select.sv
// Next-PC priority mux (jr > j/jal > taken branch > pc+4).
// With IFETCH_MISALIGN_TRAP_EN, a misaligned target is flagged; otherwise it is forced to word alignment.
module npc_select
   import ifetch_unit_pkg::*;
#(
   parameter int PC_WIDTH = DEFAULT_PC_WIDTH
) (
   input  logic [PC_WIDTH-1:0]              pc_plus4,
   input  logic [TARGET_MSB-TARGET_LSB:0]   target,
   input  logic                             Branch,
   input  logic                             nBranch,
   input  logic                             Jmp,
   input  logic                             Jal,
   input  logic                             Jr,
   input  logic                             Zero,
   input  logic [PC_WIDTH-1:0]              Addr_result,
   input  logic [PC_WIDTH-1:0]              Read_data_1,
   output logic [PC_WIDTH-1:0]              npc,
   output logic                             misaligned
);

   localparam logic [PC_WIDTH-1:0] ALIGN_MASK = {{(PC_WIDTH-2){1'b1}}, 2'b00};

   logic [PC_WIDTH-1:0] raw_npc;
   logic                taken;

   assign taken = (Branch & Zero) | (nBranch & ~Zero);

   always_comb begin
      raw_npc = pc_plus4;
      if (Jr) begin
         raw_npc = Read_data_1;
      end else if (Jmp | Jal) begin
         raw_npc = {pc_plus4[PC_WIDTH-1:28], target, 2'b00};
      end else if (taken) begin
         raw_npc = Addr_result;
      end
   end

`ifdef IFETCH_MISALIGN_TRAP_EN
   assign npc        = raw_npc;
   assign misaligned = (raw_npc[1:0] != 2'b00);
`else
   assign npc        = raw_npc & ALIGN_MASK;
   assign misaligned = 1'b0;
`endif

endmodule

// File: rtl/ifetch_unit.sv
// Fetch stage of the multi-cycle MIPS core: owns the PC, fetches over a req/ack
// handshake and advances on exec_done. Optional trap: IFETCH_MISALIGN_TRAP_EN.
module ifetch_unit
   import ifetch_unit_pkg::*;
#(
   parameter int                  PC_WIDTH = DEFAULT_PC_WIDTH,
   parameter logic [PC_WIDTH-1:0] RESET_PC = PC_WIDTH'(DEFAULT_RESET_PC)
) (
   input  logic                clock,
   input  logic                rst_n,
   output logic                imem_req,
   output logic [PC_WIDTH-1:0] imem_addr,
   input  logic                imem_ack,
   input  logic [31:0]         imem_rdata,
   input  logic                exec_done,
   input  logic                Branch,
   input  logic                nBranch,
   input  logic                Jmp,
   input  logic                Jal,
   input  logic                Jr,
   input  logic                Zero,
   input  logic [PC_WIDTH-1:0] Addr_result,
   input  logic [PC_WIDTH-1:0] Read_data_1,
   output logic [31:0]         Instruction,
   output logic                inst_valid,
   output logic [PC_WIDTH-1:0] pc,
   output logic [PC_WIDTH-1:0] link_addr,
   output logic                fetch_fault
);

   localparam logic [PC_WIDTH-1:0] PC_STEP = {{(PC_WIDTH-3){1'b0}}, 3'd4};

   state_t              state;
   state_t              next_state;
   logic [PC_WIDTH-1:0] pc_plus4;
   logic [PC_WIDTH-1:0] npc;
   logic                misaligned;
   logic                fetch_load;
   logic                retire;
   logic                fault_enter;

   assign pc_plus4  = pc + PC_STEP;
   assign imem_addr = pc;

   npc_select #(
      .PC_WIDTH (PC_WIDTH)
   ) u_npc_select (
      .pc_plus4    (pc_plus4),
      .target      (Instruction[TARGET_MSB:TARGET_LSB]),
      .Branch      (Branch),
      .nBranch     (nBranch),
      .Jmp         (Jmp),
      .Jal         (Jal),
      .Jr          (Jr),
      .Zero        (Zero),
      .Addr_result (Addr_result),
      .Read_data_1 (Read_data_1),
      .npc         (npc),
      .misaligned  (misaligned)
   );

   always_ff @(posedge clock or negedge rst_n) begin
      if (!rst_n) begin
         state <= S_REQ;
      end else begin
         state <= next_state;
      end
   end

   // imem_req is gated by rst_n so it falls the instant reset asserts, not at the next edge.
   always_comb begin
      next_state  = state;
      imem_req    = 1'b0;
      fetch_load  = 1'b0;
      retire      = 1'b0;
      fault_enter = 1'b0;
      case (state)
         S_REQ: begin
            imem_req = rst_n;
            if (imem_ack) begin
               fetch_load = 1'b1;
               next_state = S_EXEC;
            end
         end
         S_EXEC: begin
            if (exec_done) begin
               if (misaligned) begin
                  fault_enter = 1'b1;
                  next_state  = S_FAULT;
               end else begin
                  retire     = 1'b1;
                  next_state = S_REQ;
               end
            end
         end
         S_FAULT: begin
            next_state = S_FAULT;
         end
         default: begin
            next_state = S_REQ;
         end
      endcase
   end

   always_ff @(posedge clock or negedge rst_n) begin
      if (!rst_n) begin
         pc          <= RESET_PC;
         Instruction <= 32'h0;
         inst_valid  <= 1'b0;
         link_addr   <= '0;
      end else begin
         if (fetch_load) begin
            Instruction <= imem_rdata;
            inst_valid  <= 1'b1;
         end
         if (retire) begin
            pc         <= npc;
            inst_valid <= 1'b0;
            if (Jal) begin
               link_addr <= pc_plus4;
            end
         end
         if (fault_enter) begin
            inst_valid <= 1'b0;
         end
      end
   end

`ifdef IFETCH_MISALIGN_TRAP_EN
   assign fetch_fault = (state == S_FAULT);
`else
   assign fetch_fault = 1'b0;
`endif

endmodule

// File: tb/tb_ifetch_unit.sv
// Directed bench for ifetch_unit: handshake, next-PC priority, wrap, reset abort
// and misaligned targets (both IFETCH_MISALIGN_TRAP_EN builds).
module tb_ifetch_unit;

   logic        clock = 1'b0;
   logic        rst_n;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_ack;
   logic [31:0] imem_rdata;
   logic        exec_done;
   logic        Branch, nBranch, Jmp, Jal, Jr, Zero;
   logic [31:0] Addr_result;
   logic [31:0] Read_data_1;
   logic [31:0] Instruction;
   logic        inst_valid;
   logic [31:0] pc;
   logic [31:0] link_addr;
   logic        fetch_fault;

   int vectors     = 0;
   int miscompares = 0;

   ifetch_unit dut (
      .clock       (clock),
      .rst_n       (rst_n),
      .imem_req    (imem_req),
      .imem_addr   (imem_addr),
      .imem_ack    (imem_ack),
      .imem_rdata  (imem_rdata),
      .exec_done   (exec_done),
      .Branch      (Branch),
      .nBranch     (nBranch),
      .Jmp         (Jmp),
      .Jal         (Jal),
      .Jr          (Jr),
      .Zero        (Zero),
      .Addr_result (Addr_result),
      .Read_data_1 (Read_data_1),
      .Instruction (Instruction),
      .inst_valid  (inst_valid),
      .pc          (pc),
      .link_addr   (link_addr),
      .fetch_fault (fetch_fault)
   );

   always #5 clock = ~clock;

   task automatic clear_inputs();
      imem_ack    = 1'b0;
      imem_rdata  = 32'h0;
      exec_done   = 1'b0;
      Branch      = 1'b0;
      nBranch     = 1'b0;
      Jmp         = 1'b0;
      Jal         = 1'b0;
      Jr          = 1'b0;
      Zero        = 1'b0;
      Addr_result = 32'h0;
      Read_data_1 = 32'h0;
   endtask

   // Called 1 time unit after a rising edge while the DUT waits in S_REQ.
   task automatic fetch(input logic [31:0] word, input int waits);
      imem_ack = 1'b0;
      repeat (waits) begin
         @(posedge clock); #1;
      end
      imem_ack   = 1'b1;
      imem_rdata = word;
      @(posedge clock); #1;
      imem_ack   = 1'b0;
   endtask

   task automatic retire(input logic br, input logic nbr, input logic jmp, input logic jal,
                         input logic jr, input logic zero, input logic [31:0] addr,
                         input logic [31:0] rd1);
      Branch = br; nBranch = nbr; Jmp = jmp; Jal = jal; Jr = jr; Zero = zero;
      Addr_result = addr; Read_data_1 = rd1; exec_done = 1'b1;
      @(posedge clock); #1;
      clear_inputs();
   endtask

   task automatic test_reset();
      clear_inputs();
      rst_n = 1'b0;
      #2;
      vectors++; if (imem_req !== 1'b0) begin miscompares++; $display("FAIL rst_req: got %b want 0", imem_req); end
      vectors++; if (pc !== 32'h0) begin miscompares++; $display("FAIL rst_pc: got %h want 0", pc); end
      vectors++; if (Instruction !== 32'h0) begin miscompares++; $display("FAIL rst_instr: got %h want 0", Instruction); end
      vectors++; if (inst_valid !== 1'b0) begin miscompares++; $display("FAIL rst_valid: got %b want 0", inst_valid); end
      vectors++; if (link_addr !== 32'h0) begin miscompares++; $display("FAIL rst_link: got %h want 0", link_addr); end
      vectors++; if (fetch_fault !== 1'b0) begin miscompares++; $display("FAIL rst_fault: got %b want 0", fetch_fault); end
      repeat (2) @(posedge clock);
      @(negedge clock);
      rst_n = 1'b1;
      @(posedge clock); #1;
      vectors++; if (imem_req !== 1'b1) begin miscompares++; $display("FAIL rel_req: got %b want 1", imem_req); end
      vectors++; if (imem_addr !== 32'h0) begin miscompares++; $display("FAIL rel_addr: got %h want 0", imem_addr); end
   endtask

   task automatic test_fetch();
      // exec_done with a jr in the first wait cycle must be ignored in S_REQ
      exec_done = 1'b1; Jr = 1'b1; Read_data_1 = 32'h40;
      @(posedge clock); #1;
      clear_inputs();
      vectors++; if (pc !== 32'h0) begin miscompares++; $display("FAIL wait_pc: got %h want 0", pc); end
      vectors++; if (imem_req !== 1'b1) begin miscompares++; $display("FAIL wait_req: got %b want 1", imem_req); end
      @(posedge clock); #1;
      vectors++; if (imem_addr !== 32'h0) begin miscompares++; $display("FAIL wait_addr: got %h want 0", imem_addr); end
      fetch(32'h2008_0005, 0);
      vectors++; if (Instruction !== 32'h2008_0005) begin miscompares++; $display("FAIL fetch_instr: got %h want 20080005", Instruction); end
      vectors++; if (inst_valid !== 1'b1) begin miscompares++; $display("FAIL fetch_valid: got %b want 1", inst_valid); end
      vectors++; if (imem_req !== 1'b0) begin miscompares++; $display("FAIL exec_req: got %b want 0", imem_req); end
      imem_ack = 1'b1; imem_rdata = 32'hDEAD_BEEF;
      @(posedge clock); #1;
      clear_inputs();
      vectors++; if (Instruction !== 32'h2008_0005) begin miscompares++; $display("FAIL exec_ack_ignored: got %h want 20080005", Instruction); end
      retire(0, 0, 0, 0, 0, 0, 32'h0, 32'h0);
      vectors++; if (pc !== 32'h4) begin miscompares++; $display("FAIL seq_pc: got %h want 4", pc); end
      vectors++; if (imem_req !== 1'b1) begin miscompares++; $display("FAIL seq_req: got %b want 1", imem_req); end
      vectors++; if (imem_addr !== 32'h4) begin miscompares++; $display("FAIL seq_addr: got %h want 4", imem_addr); end
      vectors++; if (inst_valid !== 1'b0) begin miscompares++; $display("FAIL seq_valid: got %b want 0", inst_valid); end
   endtask

   task automatic test_branch();
      fetch(32'h0, 0); retire(0, 0, 0, 0, 1, 0, 32'h0, 32'h10);
      vectors++; if (pc !== 32'h10) begin miscompares++; $display("FAIL jr_pc: got %h want 10", pc); end
      fetch(32'h1000_0003, 1); retire(1, 0, 0, 0, 0, 1, 32'h40, 32'h0);
      vectors++; if (pc !== 32'h40) begin miscompares++; $display("FAIL beq_taken: got %h want 40", pc); end
      fetch(32'h0, 0); retire(0, 0, 0, 0, 1, 0, 32'h0, 32'h10);
      fetch(32'h1000_0003, 0); retire(1, 0, 0, 0, 0, 0, 32'h40, 32'h0);
      vectors++; if (pc !== 32'h14) begin miscompares++; $display("FAIL beq_not_taken: got %h want 14", pc); end
      fetch(32'h0, 0); retire(0, 0, 0, 0, 1, 0, 32'h0, 32'h10);
      fetch(32'h1400_0003, 0); retire(0, 1, 0, 0, 0, 0, 32'h40, 32'h0);
      vectors++; if (pc !== 32'h40) begin miscompares++; $display("FAIL bne_taken: got %h want 40", pc); end
      fetch(32'h1400_0003, 0); retire(0, 1, 0, 0, 0, 1, 32'h80, 32'h0);
      vectors++; if (pc !== 32'h44) begin miscompares++; $display("FAIL bne_not_taken: got %h want 44", pc); end
   endtask

   task automatic test_jump();
      fetch(32'h0, 0); retire(0, 0, 0, 0, 1, 0, 32'h0, 32'h0040_0008);
      fetch(32'h0C00_0100, 0); retire(0, 0, 0, 1, 0, 0, 32'h0, 32'h0);
      vectors++; if (pc !== 32'h0000_0400) begin miscompares++; $display("FAIL jal_pc: got %h want 00000400", pc); end
      vectors++; if (link_addr !== 32'h0040_000C) begin miscompares++; $display("FAIL jal_link: got %h want 0040000c", link_addr); end
      fetch(32'h0, 0); retire(0, 0, 0, 0, 1, 0, 32'h0, 32'h9000_0010);
      fetch(32'h0800_0123, 0); retire(0, 0, 1, 0, 0, 0, 32'h0, 32'h0);
      vectors++; if (pc !== 32'h9000_048C) begin miscompares++; $display("FAIL j_region: got %h want 9000048c", pc); end
      vectors++; if (link_addr !== 32'h0040_000C) begin miscompares++; $display("FAIL j_link_kept: got %h want 0040000c", link_addr); end
   endtask

   task automatic test_priority();
      fetch(32'h0800_0010, 0); retire(1, 0, 1, 0, 1, 1, 32'h40, 32'h80);
      vectors++; if (pc !== 32'h80) begin miscompares++; $display("FAIL jr_wins: got %h want 80", pc); end
      fetch(32'h0800_0030, 0); retire(1, 0, 1, 0, 0, 1, 32'h40, 32'h0);
      vectors++; if (pc !== 32'hC0) begin miscompares++; $display("FAIL jmp_over_branch: got %h want c0", pc); end
      fetch(32'h0, 0); retire(0, 0, 0, 0, 1, 0, 32'h0, 32'hFFFF_FFFC);
      fetch(32'h0, 2); retire(0, 0, 0, 0, 0, 0, 32'h0, 32'h0);
      vectors++; if (pc !== 32'h0) begin miscompares++; $display("FAIL pc_wrap: got %h want 0", pc); end
      vectors++; if (imem_addr !== 32'h0) begin miscompares++; $display("FAIL wrap_addr: got %h want 0", imem_addr); end
   endtask

   task automatic test_reset_midfetch();
      fetch(32'h0, 0); retire(0, 0, 0, 0, 1, 0, 32'h0, 32'h100);
      vectors++; if (imem_addr !== 32'h100) begin miscompares++; $display("FAIL pre_rst_addr: got %h want 100", imem_addr); end
      @(posedge clock); #3;
      rst_n = 1'b0;
      #1;
      vectors++; if (imem_req !== 1'b0) begin miscompares++; $display("FAIL midrst_req: got %b want 0", imem_req); end
      vectors++; if (pc !== 32'h0) begin miscompares++; $display("FAIL midrst_pc: got %h want 0", pc); end
      vectors++; if (link_addr !== 32'h0) begin miscompares++; $display("FAIL midrst_link: got %h want 0", link_addr); end
      @(negedge clock);
      rst_n = 1'b1;
      #1;
      vectors++; if (imem_req !== 1'b1) begin miscompares++; $display("FAIL refetch_req: got %b want 1", imem_req); end
      vectors++; if (imem_addr !== 32'h0) begin miscompares++; $display("FAIL refetch_addr: got %h want 0", imem_addr); end
      imem_ack = 1'b1; imem_rdata = 32'h1234_5678;
      @(posedge clock); #1;
      clear_inputs();
      vectors++; if (Instruction !== 32'h1234_5678) begin miscompares++; $display("FAIL late_ack_instr: got %h want 12345678", Instruction); end
      vectors++; if (inst_valid !== 1'b1) begin miscompares++; $display("FAIL late_ack_valid: got %b want 1", inst_valid); end
   endtask

   task automatic test_misalign();
      retire(0, 0, 0, 0, 1, 0, 32'h0, 32'h82);
`ifdef IFETCH_MISALIGN_TRAP_EN
      vectors++; if (fetch_fault !== 1'b1) begin miscompares++; $display("FAIL trap_fault: got %b want 1", fetch_fault); end
      vectors++; if (pc !== 32'h0) begin miscompares++; $display("FAIL trap_pc: got %h want 0", pc); end
      vectors++; if (imem_req !== 1'b0) begin miscompares++; $display("FAIL trap_req: got %b want 0", imem_req); end
      vectors++; if (inst_valid !== 1'b0) begin miscompares++; $display("FAIL trap_valid: got %b want 0", inst_valid); end
      imem_ack = 1'b1; exec_done = 1'b1; Read_data_1 = 32'h40;
      repeat (2) @(posedge clock);
      #1;
      clear_inputs();
      vectors++; if (fetch_fault !== 1'b1) begin miscompares++; $display("FAIL trap_hold: got %b want 1", fetch_fault); end
      vectors++; if (imem_req !== 1'b0) begin miscompares++; $display("FAIL trap_hold_req: got %b want 0", imem_req); end
      vectors++; if (pc !== 32'h0) begin miscompares++; $display("FAIL trap_hold_pc: got %h want 0", pc); end
`else
      vectors++; if (pc !== 32'h80) begin miscompares++; $display("FAIL align_pc: got %h want 80", pc); end
      vectors++; if (fetch_fault !== 1'b0) begin miscompares++; $display("FAIL align_fault: got %b want 0", fetch_fault); end
      vectors++; if (imem_req !== 1'b1) begin miscompares++; $display("FAIL align_req: got %b want 1", imem_req); end
`endif
   endtask

   initial begin
      #200000;
      $display("FAIL timeout: simulation exceeded time budget");
      $fatal(1, "[TB] timeout");
   end

   initial begin
      test_reset();
      test_fetch();
      test_branch();
      test_jump();
      test_priority();
      test_reset_midfetch();
      test_misalign();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
